// File: rtl/midi_tx.sv
// -----------------------------------------------------------------------------
// midi_tx
// Builds a 3-byte MIDI Channel Voice Message (Note On / Note Off) for one fixed
// channel and shifts it out on a UART line: 8N1, LSB first.
// The three bytes go out back-to-back with no idle gap between frames.
//
// Ports
//   clk_i          system clock, rising edge
//   nrst_i         asynchronous active-low reset
//   noteOnStrb_i   one-cycle request to send Note On  (status 0x9n)
//   noteOffStrb_i  one-cycle request to send Note Off (status 0x8n); wins over
//                  Note On when both strobes arrive together
//   note_i         note number; only bits [6:0] are transmitted
//   velocity_i     7-bit velocity, sent as the third byte
//   ready_o        high while idle and able to accept a request
//   tx_o           registered MIDI serial line, idles high
//   doneStrb_o     one-cycle pulse once the last stop bit has completed
// -----------------------------------------------------------------------------
`ifndef MIDI_PAYLOAD_BITS
`define MIDI_PAYLOAD_BITS 8
`endif

module midi_tx #(
  parameter int MIDI_CHANNEL = 0,
  parameter int CLK_FREQ     = 10000000,
  parameter int BAUD         = 31250
) (
  input  logic                          clk_i,
  input  logic                          nrst_i,
  input  logic                          noteOnStrb_i,
  input  logic                          noteOffStrb_i,
  input  logic [`MIDI_PAYLOAD_BITS-1:0] note_i,
  input  logic [6:0]                    velocity_i,
  output logic                          ready_o,
  output logic                          tx_o,
  output logic                          doneStrb_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       CHAN     = 4'(MIDI_CHANNEL);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]       state;
  logic             startPend;
  logic [CNT_W-1:0] baudCnt;
  logic [2:0]       bitCnt;
  logic [1:0]       byteIdx;
  logic [7:0]       shiftReg;
  logic             isNoteOn;
  logic [6:0]       noteByte;
  logic [6:0]       velByte;
  logic             accept;
  logic             bitEnd;

  // Upper payload bits of note_i are never transmitted (data bytes carry a 0 MSB).
  logic unused_note_msbs;
  assign unused_note_msbs = &{1'b0, note_i[`MIDI_PAYLOAD_BITS-1:7]};

  // startPend covers the single cycle between the accept edge and the first
  // start bit, so ready_o already drops in the cycle after acceptance.
  assign ready_o = (state == ST_IDLE) && !startPend;
  assign accept  = ready_o && (noteOnStrb_i || noteOffStrb_i);
  assign bitEnd  = (baudCnt == CNT_LAST);

  // Transmit FSM. tx_o is written only from this register block, and each
  // new line level is loaded on the same edge that enters the bit, so the
  // baud counter restarts at every bit boundary and cannot drift.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state      <= ST_IDLE;
      startPend  <= 1'b0;
      baudCnt    <= '0;
      bitCnt     <= '0;
      byteIdx    <= '0;
      shiftReg   <= '0;
      isNoteOn   <= 1'b0;
      noteByte   <= '0;
      velByte    <= '0;
      tx_o       <= 1'b1;
      doneStrb_o <= 1'b0;
    end else begin
      doneStrb_o <= 1'b0;

      if (accept) begin
        startPend <= 1'b1;
        isNoteOn  <= noteOnStrb_i && !noteOffStrb_i;
        noteByte  <= note_i[6:0];
        velByte   <= velocity_i;
      end

      case (state)
        ST_IDLE: begin
          if (startPend) begin
            startPend <= 1'b0;
            state     <= ST_START;
            tx_o      <= 1'b0;
            baudCnt   <= '0;
            byteIdx   <= '0;
            shiftReg  <= {(isNoteOn ? 4'h9 : 4'h8), CHAN};
          end
        end

        ST_START: begin
          if (bitEnd) begin
            baudCnt <= '0;
            bitCnt  <= '0;
            state   <= ST_DATA;
            tx_o    <= shiftReg[0];
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (bitEnd) begin
            baudCnt <= '0;
            if (bitCnt == 3'd7) begin
              state <= ST_STOP;
              tx_o  <= 1'b1;
            end else begin
              shiftReg <= {1'b0, shiftReg[7:1]};
              tx_o     <= shiftReg[1];
              bitCnt   <= bitCnt + 3'd1;
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (bitEnd) begin
            baudCnt <= '0;
            if (byteIdx < 2'd2) begin
              byteIdx  <= byteIdx + 2'd1;
              shiftReg <= (byteIdx == 2'd0) ? {1'b0, noteByte} : {1'b0, velByte};
              state    <= ST_START;
              tx_o     <= 1'b0;
            end else begin
              state      <= ST_IDLE;
              tx_o       <= 1'b1;
              doneStrb_o <= 1'b1;
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_tx.sv
// -----------------------------------------------------------------------------
// tb_midi_tx
// Self-checking bench for midi_tx. Two instances: a default-rate one on
// channel 0 (320 clocks per bit) and a fast one on channel 5 whose bit
// period comes from an integer division that truncates (1 MHz / 120 kbaud
// = 8 clocks per bit). The expected line waveform is derived from the
// message bytes with plain arithmetic: bit slot = cycle / clocksPerBit,
// frame = slot / 10, position in frame = slot % 10.
// -----------------------------------------------------------------------------
module tb_midi_tx;

  localparam int CPB0 = 320;
  localparam int CPB5 = 8;

  logic       clk_i = 1'b0;
  logic       nrst_i;
  logic       sel;
  logic       noteOn;
  logic       noteOff;
  logic [7:0] note;
  logic [6:0] vel;

  logic on0, off0, on5, off5;
  logic ready0, tx0, done0;
  logic ready5, tx5, done5;
  logic readyM, txM, doneM;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  // Strobes are routed only to the instance currently under test.
  assign on0    = noteOn  & ~sel;
  assign off0   = noteOff & ~sel;
  assign on5    = noteOn  &  sel;
  assign off5   = noteOff &  sel;
  assign readyM = sel ? ready5 : ready0;
  assign txM    = sel ? tx5    : tx0;
  assign doneM  = sel ? done5  : done0;

  midi_tx #(.MIDI_CHANNEL(0), .CLK_FREQ(10000000), .BAUD(31250)) dut0 (
    .clk_i(clk_i), .nrst_i(nrst_i),
    .noteOnStrb_i(on0), .noteOffStrb_i(off0),
    .note_i(note), .velocity_i(vel),
    .ready_o(ready0), .tx_o(tx0), .doneStrb_o(done0)
  );

  midi_tx #(.MIDI_CHANNEL(5), .CLK_FREQ(1000000), .BAUD(120000)) dut5 (
    .clk_i(clk_i), .nrst_i(nrst_i),
    .noteOnStrb_i(on5), .noteOffStrb_i(off5),
    .note_i(note), .velocity_i(vel),
    .ready_o(ready5), .tx_o(tx5), .doneStrb_o(done5)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Sends one request at the current negedge and follows the whole message.
  // injectAt >= 0 raises a stray Note On strobe at that cycle of the message.
  task automatic applyStimulus(input bit useFast, input bit on, input bit off,
                               input logic [7:0] n, input logic [6:0] v,
                               input int injectAt);
    int         cpb;
    int         slot, pos, bIdx;
    int         lineErr, busyErr, idleErr;
    logic       expBit;
    logic [7:0] expB [3];
    logic [7:0] gotB [3];

    sel     = useFast;
    cpb     = useFast ? CPB5 : CPB0;
    expB[0] = {(off ? 4'h8 : 4'h9), (useFast ? 4'd5 : 4'd0)};
    expB[1] = {1'b0, n[6:0]};
    expB[2] = {1'b0, v};
    gotB[0] = 8'h00;
    gotB[1] = 8'h00;
    gotB[2] = 8'h00;

    checkOutput("readyBeforeReq", 32'(readyM), 32'd1);
    note    = n;
    vel     = v;
    noteOn  = on;
    noteOff = off;
    @(negedge clk_i);
    noteOn  = 1'b0;
    noteOff = 1'b0;
    note    = 8'($urandom);
    vel     = 7'($urandom);
    checkOutput("readyAfterAccept", 32'(readyM), 32'd0);
    checkOutput("txHighBeforeFall", 32'(txM), 32'd1);

    lineErr = 0;
    busyErr = 0;
    for (int i = 0; i < 30 * cpb; i++) begin
      @(negedge clk_i);
      slot = i / cpb;
      pos  = slot % 10;
      bIdx = slot / 10;
      if (pos == 0)      expBit = 1'b0;
      else if (pos == 9) expBit = 1'b1;
      else               expBit = expB[bIdx][pos-1];
      if (txM !== expBit) lineErr++;
      if (doneM !== 1'b0 || readyM !== 1'b0) busyErr++;
      if ((i % cpb) == (cpb / 2) && pos >= 1 && pos <= 8) gotB[bIdx][pos-1] = txM;
      if (i == injectAt) begin
        noteOn = 1'b1;
        note   = 8'h11;
      end else begin
        noteOn = 1'b0;
      end
    end
    @(negedge clk_i);
    noteOn = 1'b0;
    checkOutput("doneAtEnd", 32'(doneM), 32'd1);
    checkOutput("readyAtDone", 32'(readyM), 32'd1);
    checkOutput("txIdleAtDone", 32'(txM), 32'd1);
    checkOutput("lineWaveErrors", 32'(lineErr), 32'd0);
    checkOutput("busyFlagErrors", 32'(busyErr), 32'd0);
    checkOutput("statusByte", 32'(gotB[0]), 32'(expB[0]));
    checkOutput("noteByte", 32'(gotB[1]), 32'(expB[1]));
    checkOutput("velocityByte", 32'(gotB[2]), 32'(expB[2]));

    idleErr = 0;
    for (int i = 0; i < 3 * cpb; i++) begin
      @(negedge clk_i);
      if (txM !== 1'b1 || doneM !== 1'b0 || readyM !== 1'b1) idleErr++;
    end
    checkOutput("idleAfterDone", 32'(idleErr), 32'd0);
  endtask

  initial begin
    int idleErr;
    int kind;
    int inj;

    nrst_i  = 1'b0;
    sel     = 1'b0;
    noteOn  = 1'b0;
    noteOff = 1'b0;
    note    = 8'h00;
    vel     = 7'h00;

    // Reset state of both instances
    #22;
    checkOutput("rstTx0", 32'(tx0), 32'd1);
    checkOutput("rstReady0", 32'(ready0), 32'd1);
    checkOutput("rstDone0", 32'(done0), 32'd0);
    checkOutput("rstTx5", 32'(tx5), 32'd1);
    checkOutput("rstReady5", 32'(ready5), 32'd1);
    @(negedge clk_i);
    nrst_i = 1'b1;

    // Long idle: line stays high, ready, no pulses
    idleErr = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_i);
      if (tx0 !== 1'b1 || ready0 !== 1'b1 || done0 !== 1'b0) idleErr++;
    end
    checkOutput("idle1000", 32'(idleErr), 32'd0);

    $display("[TB] note on, channel 0");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C, 7'h64, -1);

    $display("[TB] note off, channel 5, note MSB stripped");
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hC5, 7'h40, -1);

    $display("[TB] simultaneous on/off");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h30, 7'h22, -1);

    $display("[TB] stray note on during byte 1");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h45, 7'h7F, 15 * CPB0);

    // Reset in the middle of a data bit of byte 1
    $display("[TB] reset mid-message");
    sel    = 1'b0;
    note   = 8'h50;
    vel    = 7'h33;
    noteOn = 1'b1;
    @(negedge clk_i);
    noteOn = 1'b0;
    for (int i = 0; i < 13 * CPB0 + CPB0 / 2; i++) @(negedge clk_i);
    #2;
    nrst_i = 1'b0;
    #1;
    checkOutput("midRstTx", 32'(tx0), 32'd1);
    checkOutput("midRstReady", 32'(ready0), 32'd1);
    checkOutput("midRstDone", 32'(done0), 32'd0);
    @(negedge clk_i);
    nrst_i  = 1'b1;
    idleErr = 0;
    for (int i = 0; i < 2 * CPB0; i++) begin
      @(negedge clk_i);
      if (tx0 !== 1'b1 || done0 !== 1'b0 || ready0 !== 1'b1) idleErr++;
    end
    checkOutput("postRstIdle", 32'(idleErr), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h2A, 7'h15, -1);

    // Randomized messages on the fast instance
    $display("[TB] randomized messages");
    for (int k = 0; k < 25; k++) begin
      kind = int'($urandom_range(0, 2));
      inj  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30 * CPB5 - 1)) : -1;
      applyStimulus(1'b1, kind != 1, kind != 0, 8'($urandom), 7'($urandom), inj);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) @(negedge clk_i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
